branch_resolve_unit: RTL and testbench

- Consumer end of the branch-prediction interface. Receives each predicted-branch record at DECODE, holds it in an in-order FIFO until EXEC resolves the branch, and compares the prediction with the actual outcome.
- Generates the pipeline flush/redirect on a mispredict.
- Drives the training/update port back into the predictor: PC, target and actual taken flag, as a single-cycle pulse.

---
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the pipeline (DECODE/EXEC/predictor side) and the
// branch resolve unit. The pipeline is the master; the resolve unit is the slave.
interface branch_resolve_unit_if #(
    parameter int AW = 32
);
    // DECODE push channel
    logic          d_push;
    logic [AW-1:0] d_pc;
    logic          d_pred_taken;
    logic [AW-1:0] d_pred_target;
    logic          d_ready;

    // EXEC resolve channel
    logic          x_resolve;
    logic          x_taken;
    logic [AW-1:0] x_target;

    // Pipeline redirect
    logic          flush;
    logic [AW-1:0] redirect_addr;

    // Predictor training port
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;

    modport master (
        output d_push, d_pc, d_pred_taken, d_pred_target,
        output x_resolve, x_taken, x_target,
        input  d_ready, flush, redirect_addr,
        input  upd_valid, upd_pc, upd_target, upd_taken
    );

    modport slave (
        input  d_push, d_pc, d_pred_taken, d_pred_target,
        input  x_resolve, x_taken, x_target,
        output d_ready, flush, redirect_addr,
        output upd_valid, upd_pc, upd_target, upd_taken
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds predicted-branch records in an in-order FIFO
// from DECODE until EXEC resolves them, raises flush/redirect on a
// mispredict and pulses a training update back into the predictor.
module branch_resolve_unit #(
    parameter int DEPTH      = 4,
    parameter int AW         = 32,
    parameter int INSN_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    branch_resolve_unit_if.slave       bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_underflow,
    output logic                       err_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Record storage (one entry per in-flight branch)
    logic [AW-1:0] pc_mem  [DEPTH];
    logic          pt_mem  [DEPTH];
    logic [AW-1:0] tgt_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          fifo_full;
    logic          fifo_empty;
    logic          do_resolve;
    logic          mispredict;
    logic          push_ok;
    logic          overflow_hit;
    logic          underflow_hit;
    logic [AW-1:0] head_pc;
    logic          head_pt;
    logic [AW-1:0] head_tgt;
    logic [AW-1:0] fallthrough;
    logic [AW-1:0] redirect_nxt;

    assign fifo_full   = (count == CW'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign bus.d_ready = ~fifo_full;

    assign head_pc     = pc_mem[rd_ptr];
    assign head_pt     = pt_mem[rd_ptr];
    assign head_tgt    = tgt_mem[rd_ptr];
    assign fallthrough = head_pc + AW'(INSN_BYTES);

    // Decode the cycle's FIFO actions and the mispredict condition
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        do_resolve    = 1'b0;
        mispredict    = 1'b0;
        push_ok       = 1'b0;
        overflow_hit  = 1'b0;
        underflow_hit = 1'b0;
        redirect_nxt  = fallthrough;

        do_resolve    = bus.x_resolve & ~fifo_empty;
        underflow_hit = bus.x_resolve &  fifo_empty;

        if (do_resolve) begin
            mispredict = (bus.x_taken != head_pt) |
                         (bus.x_taken & (head_tgt != bus.x_target));
        end

        if (bus.x_taken) begin
            redirect_nxt = bus.x_target;
        end

        // A same-cycle pop frees the slot, so a push against a full FIFO is
        // still taken; a push alongside a mispredict is wrong-path and dropped.
        push_ok      = bus.d_push & (~fifo_full | do_resolve) & ~mispredict;
        overflow_hit = bus.d_push & fifo_full & ~do_resolve;
    end

    // Pointer / occupancy bookkeeping; a mispredict empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_resolve) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(do_resolve);
        end
    end

    // Record storage write
    // NOTE: the record array has no reset; entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]  <= bus.d_pc;
            pt_mem[wr_ptr]  <= bus.d_pred_taken;
            tgt_mem[wr_ptr] <= bus.d_pred_target;
        end
    end

    // Registered flush/redirect and predictor-update pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.flush         <= 1'b0;
            bus.redirect_addr <= '0;
            bus.upd_valid     <= 1'b0;
            bus.upd_pc        <= '0;
            bus.upd_target    <= '0;
            bus.upd_taken     <= 1'b0;
        end else begin
            bus.flush     <= mispredict;
            bus.upd_valid <= do_resolve;
            if (mispredict) begin
                bus.redirect_addr <= redirect_nxt;
            end
            if (do_resolve) begin
                bus.upd_pc     <= head_pc;
                bus.upd_target <= bus.x_target;
                bus.upd_taken  <= bus.x_taken;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (underflow_hit) begin
                err_underflow <= 1'b1;
            end
            if (overflow_hit) begin
                err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed stimulus pushes the
// hand-computed expected update/flush into a queue; a monitor pops and
// compares whenever upd_valid is presented.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] target;
        logic          taken;
        logic          flush;
        logic [AW-1:0] redir;
        int            due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] count;
    logic          err_underflow;
    logic          err_overflow;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    branch_resolve_unit_if #(.AW(AW)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .INSN_BYTES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .count         (count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented update against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_upd: no upd_valid for pc 0x%0h by cycle %0d", sb[0].pc, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.upd_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_upd", bus.upd_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("upd_pc",     bus.upd_pc,     e.pc);
                    check("upd_target", bus.upd_target, e.target);
                    check("upd_taken",  bus.upd_taken,  e.taken);
                    check("flush",      bus.flush,      e.flush);
                    if (e.flush) check("redirect_addr", bus.redirect_addr, e.redir);
                end
            end else begin
                check("flush_without_upd", bus.flush, 0);
            end
        end
    end

    // One clock of stimulus; optionally records the expected resolve response
    task automatic step(input logic push, input logic [AW-1:0] pc, input logic pt,
                        input logic [AW-1:0] ptg, input logic res, input logic xt,
                        input logic [AW-1:0] xtg, input logic exp_en,
                        input logic [AW-1:0] e_pc, input logic e_flush,
                        input logic [AW-1:0] e_redir);
        bus.d_push        = push;
        bus.d_pc          = pc;
        bus.d_pred_taken  = pt;
        bus.d_pred_target = ptg;
        bus.x_resolve     = res;
        bus.x_taken       = xt;
        bus.x_target      = xtg;
        if (exp_en) begin
            exp_t e;
            e.pc = e_pc; e.target = xtg; e.taken = xt;
            e.flush = e_flush; e.redir = e_redir; e.due = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.d_push    = 1'b0;
        bus.x_resolve = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic pt, input logic [AW-1:0] ptg);
        step(1'b1, pc, pt, ptg, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic resolve(input logic xt, input logic [AW-1:0] xtg,
                           input logic [AW-1:0] e_pc, input logic e_flush,
                           input logic [AW-1:0] e_redir);
        step(1'b0, '0, 1'b0, '0, 1'b1, xt, xtg, 1'b1, e_pc, e_flush, e_redir);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.d_push = 1'b0; bus.d_pc = '0; bus.d_pred_taken = 1'b0; bus.d_pred_target = '0;
        bus.x_resolve = 1'b0; bus.x_taken = 1'b0; bus.x_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     count, 0);
        check("rst_d_ready",   bus.d_ready, 1);
        check("rst_flush",     bus.flush, 0);
        check("rst_upd_valid", bus.upd_valid, 0);
        check("rst_redirect",  bus.redirect_addr, 0);
        check("rst_upd_pc",    bus.upd_pc, 0);
        check("rst_err_uf",    err_underflow, 0);
        check("rst_err_of",    err_overflow, 0);
        rst_n = 1'b1;

        // Correctly predicted taken branch
        push(32'h100, 1'b1, 32'h140);
        check("count_after_push", count, 1);
        resolve(1'b1, 32'h140, 32'h100, 1'b0, '0);
        check("count_after_resolve", count, 0);

        // Predicted not-taken, actually taken -> redirect to target
        push(32'h200, 1'b0, 32'h0);
        resolve(1'b1, 32'h240, 32'h200, 1'b1, 32'h240);
        // Predicted taken, actually not-taken -> redirect to fall-through
        push(32'h300, 1'b1, 32'h380);
        resolve(1'b0, 32'h304, 32'h300, 1'b1, 32'h304);
        check("count_after_mispredicts", count, 0);

        // Fill, overflow, then push+pop while full across pointer wrap
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i) * 32'h10, 1'b1, 32'h440 + 32'(i) * 32'h10);
        check("full_count",   count, 4);
        check("full_d_ready", bus.d_ready, 0);
        push(32'h440, 1'b1, 32'h480);
        check("overflow_flag",  err_overflow, 1);
        check("overflow_count", count, 4);
        step(1'b1, 32'h450, 1'b1, 32'h490, 1'b1, 1'b1, 32'h440, 1'b1, 32'h400, 1'b0, '0);
        check("push_pop_full_count", count, 4);
        check("push_pop_no_uf", err_underflow, 0);
        resolve(1'b1, 32'h450, 32'h410, 1'b0, '0);
        resolve(1'b1, 32'h460, 32'h420, 1'b0, '0);
        resolve(1'b1, 32'h470, 32'h430, 1'b0, '0);
        resolve(1'b1, 32'h490, 32'h450, 1'b0, '0);
        check("drained_count", count, 0);

        // Head mispredicts with a younger push in the same cycle
        push(32'h500, 1'b0, '0);
        push(32'h510, 1'b0, '0);
        push(32'h520, 1'b0, '0);
        step(1'b1, 32'h530, 1'b0, '0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h500, 1'b1, 32'h600);
        check("flush_empties_fifo", count, 0);
        check("flush_d_ready", bus.d_ready, 1);
        push(32'h700, 1'b0, '0);
        check("post_flush_count", count, 1);
        resolve(1'b0, 32'h704, 32'h700, 1'b0, '0);

        // Resolve against an empty FIFO
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h999, 1'b0, '0, 1'b0, '0);
        check("underflow_flag", err_underflow, 1);
        check("underflow_count", count, 0);
        check("overflow_sticky", err_overflow, 1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        // Async reset with an update pulse pending and two records in flight
        push(32'h800, 1'b0, '0);
        push(32'h810, 1'b0, '0);
        push(32'h820, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h804, 1'b0, '0, 1'b0, '0);
        check("pre_rst_upd_valid", bus.upd_valid, 1);
        check("pre_rst_count", count, 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_upd_valid", bus.upd_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_err_of", err_overflow, 0);
        check("async_rst_err_uf", err_underflow, 0);
        #1 rst_n = 1'b1;

        // Async reset with a flush pulse pending
        @(posedge clk); #1;
        push(32'h900, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h999, 1'b0, '0, 1'b0, '0);
        check("pre_rst_flush", bus.flush, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_flush", bus.flush, 0);
        check("async_rst_redirect", bus.redirect_addr, 0);
        #1 rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("sb_final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
